// File: rtl/frame_buffer_db.sv
// Double-buffered frame store: pixel writes and colour fills go to the back page while the
// video side reads the front page; pages swap on the first vsync after a swap request.
module frame_buffer_db #(
    parameter int unsigned H_RES   = 640,
    parameter int unsigned V_RES   = 480,
    parameter int unsigned PIXEL_W = 24,
    parameter int unsigned XY_W    = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [XY_W-1:0]    wr_x,
    input  logic [XY_W-1:0]    wr_y,
    input  logic [PIXEL_W-1:0] wr_data,
    output logic               wr_ready,
    input  logic               rd_en,
    input  logic [XY_W-1:0]    rd_x,
    input  logic [XY_W-1:0]    rd_y,
    output logic [PIXEL_W-1:0] rd_data,
    output logic               rd_valid,
    input  logic               clear_req,
    input  logic [PIXEL_W-1:0] clear_color,
    input  logic               swap_req,
    input  logic               frame_start,
    output logic               front_page,
    output logic               busy,
    output logic               swap_done
);

    localparam int unsigned PageSz = H_RES * V_RES;
    localparam int unsigned Depth  = 2 * PageSz;
    localparam int unsigned AddrW  = $clog2(Depth);

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StSwapWait
    } state_e;

    state_e               state_q, state_d;
    logic                 front_page_q, front_page_d;
    logic                 busy_q, busy_d;
    logic                 swap_done_q, swap_done_d;
    logic                 wr_ready_q, wr_ready_d;
    logic                 pend_q, pend_d;
    logic [PIXEL_W-1:0]   clr_color_q, clr_color_d;
    logic [AddrW-1:0]     clr_cnt_q, clr_cnt_d;
    logic [PIXEL_W-1:0]   rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;

    logic [PIXEL_W-1:0]   mem [Depth];
    logic                 mem_we;
    logic [AddrW-1:0]     mem_waddr;
    logic [PIXEL_W-1:0]   mem_wdata;

    logic                 wr_in_range;
    logic                 rd_in_range;
    int unsigned          wr_off;
    int unsigned          rd_off;

    function automatic logic [AddrW-1:0] page_addr(input logic page, input int unsigned off);
        int unsigned a;
        a = page ? (PageSz + off) : off;
        return AddrW'(a);
    endfunction

    always_comb begin
        wr_in_range = (32'(wr_x) < H_RES) && (32'(wr_y) < V_RES);
        rd_in_range = (32'(rd_x) < H_RES) && (32'(rd_y) < V_RES);
        wr_off      = 32'(wr_y) * H_RES + 32'(wr_x);
        rd_off      = 32'(rd_y) * H_RES + 32'(rd_x);
    end

    // Single write port: the fill owns it while clearing, since drawing writes are refused then.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (state_q == StClear) begin
            mem_we    = 1'b1;
            mem_waddr = page_addr(!front_page_q, 32'(clr_cnt_q));
            mem_wdata = clr_color_q;
        end else if (wr_en && wr_ready_q && wr_in_range) begin
            mem_we    = 1'b1;
            mem_waddr = page_addr(!front_page_q, wr_off);
            mem_wdata = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Read uses the pre-edge front page, so a read in the toggle cycle sees the old page.
    always_comb begin
        rd_valid_d = rd_en;
        rd_data_d  = rd_data_q;
        if (rd_en) begin
            rd_data_d = rd_in_range ? mem[page_addr(front_page_q, rd_off)] : '0;
        end
    end

    always_comb begin
        state_d      = state_q;
        front_page_d = front_page_q;
        swap_done_d  = 1'b0;
        pend_d       = pend_q;
        clr_color_d  = clr_color_q;
        clr_cnt_d    = clr_cnt_q;
        case (state_q)
            StIdle: begin
                if (clear_req) begin
                    clr_color_d = clear_color;
                    clr_cnt_d   = '0;
                    pend_d      = swap_req;
                    state_d     = StClear;
                end else if (swap_req) begin
                    state_d = StSwapWait;
                end
            end
            StClear: begin
                if (clr_cnt_q == AddrW'(PageSz - 1)) begin
                    state_d = (pend_q || swap_req) ? StSwapWait : StIdle;
                    pend_d  = 1'b0;
                end else begin
                    clr_cnt_d = clr_cnt_q + AddrW'(1);
                    if (swap_req) begin
                        pend_d = 1'b1;
                    end
                end
            end
            StSwapWait: begin
                if (frame_start) begin
                    front_page_d = !front_page_q;
                    swap_done_d  = 1'b1;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d     = (state_d == StClear);
        wr_ready_d = (state_d != StClear);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            front_page_q <= 1'b0;
            busy_q       <= 1'b0;
            swap_done_q  <= 1'b0;
            wr_ready_q   <= 1'b1;
            pend_q       <= 1'b0;
            clr_color_q  <= '0;
            clr_cnt_q    <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            front_page_q <= front_page_d;
            busy_q       <= busy_d;
            swap_done_q  <= swap_done_d;
            wr_ready_q   <= wr_ready_d;
            pend_q       <= pend_d;
            clr_color_q  <= clr_color_d;
            clr_cnt_q    <= clr_cnt_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    assign wr_ready   = wr_ready_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign front_page = front_page_q;
    assign busy       = busy_q;
    assign swap_done  = swap_done_q;

endmodule

// File: tb/tb_frame_buffer_db.sv
// Directed bench for frame_buffer_db on a 4x3 8-bit frame: writes, fills, swaps, range
// drops, read timing around the page toggle and reset mid-fill.
module tb_frame_buffer_db;

    localparam int unsigned HRes = 4;
    localparam int unsigned VRes = 3;
    localparam int unsigned PixW = 8;
    localparam int unsigned XyW  = 10;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            wr_en = 1'b0;
    logic [XyW-1:0]  wr_x = '0, wr_y = '0;
    logic [PixW-1:0] wr_data = '0;
    logic            wr_ready;
    logic            rd_en = 1'b0;
    logic [XyW-1:0]  rd_x = '0, rd_y = '0;
    logic [PixW-1:0] rd_data;
    logic            rd_valid;
    logic            clear_req = 1'b0;
    logic [PixW-1:0] clear_color = '0;
    logic            swap_req = 1'b0;
    logic            frame_start = 1'b0;
    logic            front_page, busy, swap_done;

    int checks   = 0;
    int failures = 0;

    frame_buffer_db #(
        .H_RES(HRes), .V_RES(VRes), .PIXEL_W(PixW), .XY_W(XyW)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data), .rd_valid(rd_valid),
        .clear_req(clear_req), .clear_color(clear_color),
        .swap_req(swap_req), .frame_start(frame_start),
        .front_page(front_page), .busy(busy), .swap_done(swap_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // All helpers start and end just after a falling edge.
    task automatic do_write(input int x, input int y, input logic [7:0] d);
        wr_en = 1'b1; wr_x = XyW'(x); wr_y = XyW'(y); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic read_chk(input string tag, input int x, input int y, input logic [7:0] exp);
        rd_en = 1'b1; rd_x = XyW'(x); rd_y = XyW'(y);
        @(negedge clk);
        rd_en = 1'b0;
        check({tag, "_valid"}, 32'(rd_valid), 32'd1);
        check({tag, "_data"}, 32'(rd_data), 32'(exp));
    endtask

    task automatic do_swap(input string tag, input logic exp_front);
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check({tag, "_swap_done"}, 32'(swap_done), 32'd1);
        check({tag, "_front"}, 32'(front_page), 32'(exp_front));
        @(negedge clk);
        check({tag, "_swap_done_fall"}, 32'(swap_done), 32'd0);
    endtask

    // Issues clear (optionally with swap), optionally pulses frame_start at clear cycle fs_at,
    // optionally attempts a write to (0,0) every busy cycle. Returns observed cycle counts.
    task automatic run_clear(input logic [7:0] color, input logic swp, input int fs_at,
                             input logic wr_during, output int nbusy, output int nlow,
                             output int nswap);
        nbusy = 0; nlow = 0; nswap = 0;
        clear_req = 1'b1; clear_color = color; swap_req = swp;
        @(negedge clk);
        clear_req = 1'b0; swap_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (swap_done) nswap++;
            if (!busy) break;
            nbusy++;
            if (!wr_ready) nlow++;
            if (nbusy == fs_at) frame_start = 1'b1;
            if (wr_during) begin
                wr_en = 1'b1; wr_x = '0; wr_y = '0; wr_data = 8'h77;
            end
            @(negedge clk);
            frame_start = 1'b0;
            wr_en = 1'b0;
        end
        check("clear_ended", 32'(busy), 32'd0);
        check("clear_wr_ready_after", 32'(wr_ready), 32'd1);
    endtask

    int nb, nl, ns;

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_front", 32'(front_page), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_swap_done", 32'(swap_done), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write, swap on vsync, read back from the new front page.
        do_write(1, 2, 8'hA5);
        check("a_front_before", 32'(front_page), 32'd0);
        do_swap("a", 1'b1);
        read_chk("a_rd", 1, 2, 8'hA5);
        @(negedge clk);
        check("a_rd_valid_pulse", 32'(rd_valid), 32'd0);
        check("a_rd_data_hold", 32'(rd_data), 32'hA5);

        // Fill back page 0; drawing writes during the fill must be refused.
        run_clear(8'h3C, 1'b0, 0, 1'b1, nb, nl, ns);
        check("b_busy_cycles", 32'(nb), 32'd12);
        check("b_wr_ready_low", 32'(nl), 32'd12);
        do_swap("b", 1'b0);
        for (int y = 0; y < 3; y++) begin
            for (int x = 0; x < 4; x++) begin
                read_chk($sformatf("b_px%0d%0d", x, y), x, y, 8'h3C);
            end
        end

        // Out-of-range writes are dropped and out-of-range reads return zero.
        run_clear(8'h5A, 1'b0, 0, 1'b0, nb, nl, ns);
        check("c_busy_cycles", 32'(nb), 32'd12);
        do_write(4, 0, 8'hFF);
        do_write(0, 3, 8'hFF);
        read_chk("c_oor_x", 4, 0, 8'h00);
        read_chk("c_oor_y", 0, 3, 8'h00);
        do_swap("c", 1'b1);
        read_chk("c_alias01", 0, 1, 8'h5A);
        read_chk("c_px00", 0, 0, 8'h5A);
        read_chk("c_px32", 3, 2, 8'h5A);
        read_chk("c_oor_x2", 4, 0, 8'h00);
        check("c_page0_px00", 32'(u_dut.mem[0]), 32'h3C);

        // Clear and swap together: vsync during the fill must not swap.
        run_clear(8'h81, 1'b1, 5, 1'b0, nb, nl, ns);
        check("d_busy_cycles", 32'(nb), 32'd12);
        check("d_no_swap_in_clear", 32'(ns), 32'd0);
        check("d_front_hold", 32'(front_page), 32'd1);
        @(negedge clk);
        check("d_front_wait", 32'(front_page), 32'd1);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check("d_swap_done", 32'(swap_done), 32'd1);
        check("d_front_after", 32'(front_page), 32'd0);
        read_chk("d_px21", 2, 1, 8'h81);

        // Read in the toggle cycle sees the old page; the next read sees the new one.
        do_write(2, 1, 8'h42);
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        frame_start = 1'b1;
        rd_en = 1'b1; rd_x = XyW'(2); rd_y = XyW'(1);
        @(negedge clk);
        frame_start = 1'b0;
        rd_en = 1'b0;
        check("e_swap_done", 32'(swap_done), 32'd1);
        check("e_front", 32'(front_page), 32'd1);
        check("e_toggle_rd", 32'(rd_data), 32'h81);
        read_chk("e_next_rd", 2, 1, 8'h42);

        // Reset mid-fill with a swap pending; both are abandoned.
        clear_req = 1'b1; clear_color = 8'h99;
        @(negedge clk);
        clear_req = 1'b0;
        repeat (2) @(negedge clk);
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        repeat (2) @(negedge clk);
        check("f_busy_cycle6", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("f_rst_busy", 32'(busy), 32'd0);
        check("f_rst_front", 32'(front_page), 32'd0);
        check("f_rst_wr_ready", 32'(wr_ready), 32'd1);
        check("f_rst_rd_valid", 32'(rd_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_clear(8'h24, 1'b0, 0, 1'b0, nb, nl, ns);
        check("f_busy_cycles", 32'(nb), 32'd12);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check("f_no_pending_swap", 32'(swap_done), 32'd0);
        check("f_front_kept", 32'(front_page), 32'd0);
        do_swap("f", 1'b1);
        read_chk("f_px32", 3, 2, 8'h24);
        read_chk("f_px12", 1, 2, 8'h24);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1);
    end

endmodule
